// File: rtl/mac8_wb_buffer.sv
// rtl/mac8_wb_buffer.sv - in-order result/writeback buffer behind mac8_FU
//
// Purpose: captures every mac8_FU result, trans_id and exception in a small
// in-order FIFO and drains it into a writeback port that may stall. The
// functional unit itself cannot stall, so in_ready_o goes back to issue logic.
//
// Optional feature macro: MAC8_WB_BYPASS_EN (zero-cycle bypass when empty).
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   flush_i             discard all buffered entries
//   in_valid_i          result valid from mac8_FU
//   in_result_i         result data
//   in_trans_id_i       scoreboard transaction id
//   in_ex_i             packed exception record (exception_t, EX_W bits)
//   in_ready_o          at least one free entry
//   out_valid_o         head entry valid toward writeback
//   out_ready_i         writeback port accepts the head this cycle
//   out_result_o        head result (zero when empty)
//   out_trans_id_o      head transaction id (zero when empty)
//   out_ex_o            head exception (zero when empty)
//   count_o             occupied entries
//   overflow_o          sticky: a push was dropped
module mac8_wb_buffer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned EX_W          = 129
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_result_i,
  input  logic [TRANS_ID_BITS-1:0] in_trans_id_i,
  input  logic [EX_W-1:0]          in_ex_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_result_o,
  output logic [TRANS_ID_BITS-1:0] out_trans_id_o,
  output logic [EX_W-1:0]          out_ex_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DATA_W + TRANS_ID_BITS + EX_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          empty;
  logic          full;
  logic          fifo_pop;
  logic          push;
  logic          bypass;
  logic [EW-1:0] head_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef MAC8_WB_BYPASS_EN
  // Empty buffer and a willing consumer: hand the result straight through.
  assign bypass = empty & in_valid_i & out_ready_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result never touches storage, so only stored heads pop.
  assign fifo_pop = ~empty & out_ready_i;
  // When full, a same-cycle pop frees the slot the push reuses.
  assign push     = in_valid_i & ~flush_i & ~bypass & (~full | fifo_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !fifo_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && fifo_pop) begin
      count_d = count_q - 1'b1;
    end

    // A flush-cycle push is discarded on purpose, not counted as a drop.
    if (in_valid_i && full && !fifo_pop && !flush_i) begin
      overflow_d = 1'b1;
    end

    // Flush wins over push/pop bookkeeping; the sticky flag survives it.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; empty-state outputs are forced to zero below.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= {in_ex_i, in_trans_id_i, in_result_i};
    end
  end

  always_comb begin
    head_entry     = mem_q[rd_ptr_q];
    out_valid_o    = ~empty;
    out_result_o   = '0;
    out_trans_id_o = '0;
    out_ex_o       = '0;
    if (!empty) begin
      {out_ex_o, out_trans_id_o, out_result_o} = head_entry;
    end
`ifdef MAC8_WB_BYPASS_EN
    if (bypass) begin
      out_valid_o    = 1'b1;
      out_result_o   = in_result_i;
      out_trans_id_o = in_trans_id_i;
      out_ex_o       = in_ex_i;
    end
`endif
  end

  assign in_ready_o = ~full;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
